// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: one partial-product add per clock
// through a carry-lookahead adder, with valid/ready handshakes on both sides.

module nBitCarryLookAheadAdder #(
    parameter int NUMBITS = 8
) (
    input  logic [NUMBITS-1:0] a_in,
    input  logic [NUMBITS-1:0] b_in,
    input  logic               c_in,
    output logic [NUMBITS-1:0] s_out,
    output logic               c_out
);

    logic [NUMBITS-1:0] g_s;
    logic [NUMBITS-1:0] p_s;
    logic [NUMBITS:0]   c_s;
    logic               carry_s;

    assign g_s = a_in & b_in;
    assign p_s = a_in ^ b_in;

    // Each carry is expanded independently from generate/propagate terms.
    always_comb begin
        c_s     = {(NUMBITS+1){1'b0}};
        carry_s = 1'b0;
        c_s[0]  = c_in;
        for (int i = 0; i < NUMBITS; i++) begin
            carry_s = c_in;
            for (int j = 0; j <= i; j++) begin
                carry_s = g_s[j] | (p_s[j] & carry_s);
            end
            c_s[i+1] = carry_s;
        end
    end

    assign s_out = p_s ^ c_s[NUMBITS-1:0];
    assign c_out = c_s[NUMBITS];

endmodule

module seq_shift_add_multiplier #(
    parameter int NUMBITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [NUMBITS-1:0]     a_in,
    input  logic [NUMBITS-1:0]     b_in,
    output logic [2*NUMBITS-1:0]   product_out,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic                   busy
);

    localparam int CW = (NUMBITS > 2) ? $clog2(NUMBITS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_COUNT = CW'(NUMBITS - 1);

    logic [1:0]           state_q,   state_d;
    logic [NUMBITS-1:0]   mcand_q,   mcand_d;
    // High accumulator; the adder carry lands in its top bit on every shift,
    // so the extra carry-position bit is always zero and is not stored.
    logic [NUMBITS-1:0]   acc_q,     acc_d;
    logic [NUMBITS-1:0]   lo_q,      lo_d;
    logic [CW-1:0]        count_q,   count_d;
    logic [2*NUMBITS-1:0] product_q, product_d;
    logic                 start_ready_q;
    logic                 done_valid_q;
    logic                 busy_q;

    logic [NUMBITS-1:0]   add_b_s;
    logic [NUMBITS-1:0]   add_s_s;
    logic                 add_c_s;

    assign add_b_s = lo_q[0] ? mcand_q : {NUMBITS{1'b0}};

    nBitCarryLookAheadAdder #(.NUMBITS(NUMBITS)) u_cla (
        .a_in  (acc_q),
        .b_in  (add_b_s),
        .c_in  (1'b0),
        .s_out (add_s_s),
        .c_out (add_c_s)
    );

    // Next-state, datapath shift and result capture.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    mcand_d = a_in;
                    lo_d    = b_in;
                    acc_d   = {NUMBITS{1'b0}};
                    count_d = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = {add_c_s, add_s_s[NUMBITS-1:1]};
                lo_d    = {add_s_s[0], lo_q[NUMBITS-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    state_d   = ST_DONE;
                    product_d = {acc_d, lo_d};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered handshake outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mcand_q       <= {NUMBITS{1'b0}};
            acc_q         <= {NUMBITS{1'b0}};
            lo_q          <= {NUMBITS{1'b0}};
            count_q       <= {CW{1'b0}};
            product_q     <= {(2*NUMBITS){1'b0}};
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mcand_q       <= mcand_d;
            acc_q         <= acc_d;
            lo_q          <= lo_d;
            count_q       <= count_d;
            product_q     <= product_d;
            start_ready_q <= (state_d == ST_IDLE);
            done_valid_q  <= (state_d == ST_DONE);
            busy_q        <= (state_d == ST_RUN);
        end
    end

    assign start_ready = start_ready_q;
    assign done_valid  = done_valid_q;
    assign busy        = busy_q;
    assign product_out = product_q;

endmodule
